// File: rtl/coin_input_conditioner.sv
// Coin pushbutton front end: synchronises, debounces and edge-detects three buttons, queues
// presses and issues spaced, one-hot, single-cycle coin pulses to the vending FSM.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GAP_CYCLES      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_nickel,
    input  logic       btn_dime,
    input  logic       btn_quarter,
    output logic [2:0] coin,
    output logic       busy,
    output logic       coin_dropped
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Nickel has priority over dime, dime over quarter.
    function automatic logic [2:0] lowest_onehot(input logic [2:0] req);
        logic [2:0] sel;
        sel = 3'b000;
        if (req[0]) begin
            sel = 3'b001;
        end else if (req[1]) begin
            sel = 3'b010;
        end else if (req[2]) begin
            sel = 3'b100;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    logic [2:0] btn_s;
    logic [2:0] db_s;
    logic [2:0] db_q_s;
    logic [2:0] rise_s;

    assign btn_s  = {btn_quarter, btn_dime, btn_nickel};
    assign rise_s = db_s & ~db_q_s;

    genvar ch;
    generate
        for (ch = 0; ch < 3; ch++) begin : g_chan
            logic            sync1_r;
            logic            sync2_r;
            logic            db_r;
            logic            db_q_r;
            logic [DB_W-1:0] cnt_r;

            // Per-button synchroniser, debounce counter and debounced-level history
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_r <= 1'b0;
                    sync2_r <= 1'b0;
                    db_r    <= 1'b0;
                    db_q_r  <= 1'b0;
                    cnt_r   <= {DB_W{1'b0}};
                end else begin
                    sync1_r <= btn_s[ch];
                    sync2_r <= sync1_r;
                    db_q_r  <= db_r;
                    if (sync2_r == db_r) begin
                        cnt_r <= {DB_W{1'b0}};
                    end else if (cnt_r == DB_LAST) begin
                        db_r  <= ~db_r;
                        cnt_r <= {DB_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + DB_W'(1'b1);
                    end
                end
            end

            assign db_s[ch]   = db_r;
            assign db_q_s[ch] = db_q_r;
        end
    endgenerate

    state_t           state_r;
    state_t           state_nxt_s;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [GAP_W-1:0] gap_cnt_nxt_s;
    logic [2:0]       pend_r;
    logic [2:0]       pend_nxt_s;
    logic [2:0]       grant_s;
    logic [2:0]       drop_s;
    logic [2:0]       coin_nxt_s;
    logic [2:0]       coin_r;
    logic             busy_r;
    logic             dropped_r;

    // Arbiter next state, grant selection and pending-flag update
    always_comb begin
        state_nxt_s   = state_r;
        gap_cnt_nxt_s = gap_cnt_r;
        grant_s       = 3'b000;
        coin_nxt_s    = 3'b000;
        case (state_r)
            IDLE: begin
                if (pend_r != 3'b000) begin
                    grant_s     = lowest_onehot(pend_r);
                    coin_nxt_s  = grant_s;
                    state_nxt_s = PULSE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PULSE: begin
                state_nxt_s   = GAP;
                gap_cnt_nxt_s = {GAP_W{1'b0}};
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // A new press on an already-queued button that is not being served is lost.
        drop_s     = rise_s & pend_r & ~grant_s;
        pend_nxt_s = (pend_r & ~grant_s) | rise_s;
    end

    // Arbiter state, pending flags and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            gap_cnt_r <= {GAP_W{1'b0}};
            pend_r    <= 3'b000;
            coin_r    <= 3'b000;
            busy_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            pend_r    <= pend_nxt_s;
            coin_r    <= coin_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            dropped_r <= |drop_s;
        end
    end

    assign coin         = coin_r;
    assign busy         = busy_r;
    assign coin_dropped = dropped_r;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner: edge-indexed behavioural model compared every
// cycle, plus hand-computed pulse timings for each scenario.
module tb_coin_input_conditioner;
    localparam int DB  = 4;
    localparam int GAP = 3;
    localparam int HIST = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_nickel;
    logic       btn_dime;
    logic       btn_quarter;
    logic [2:0] coin;
    logic       busy;
    logic       coin_dropped;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_nickel  (btn_nickel),
        .btn_dime    (btn_dime),
        .btn_quarter (btn_quarter),
        .coin        (coin),
        .busy        (busy),
        .coin_dropped(coin_dropped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model, indexed by clock edge ----------------
    int         ecount     = 0;
    int         last_rst   = 0;
    int         last_start = -1000;
    logic [2:0] raw_hist [HIST];
    logic [2:0] m_db   = 3'b000;
    logic [2:0] m_rise = 3'b000;
    logic [2:0] m_pend = 3'b000;
    logic [2:0] m_coin = 3'b000;
    logic       m_busy = 1'b0;
    logic       m_drop = 1'b0;
    logic [2:0] new_db;
    logic [2:0] grant;
    logic       flips;

    // Synchronised sample seen by the debouncer at edge e: raw button two edges earlier,
    // or 0 if that sample predates the last reset.
    function automatic logic sout(input int e, input int ch);
        logic [2:0] v;
        if ((e - 2 > last_rst) && (e - 2 >= 0)) begin
            v = raw_hist[(e - 2) % HIST];
            return v[ch];
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        ecount = ecount + 1;
        raw_hist[ecount % HIST] = {btn_quarter, btn_dime, btn_nickel};
        if (reset) begin
            m_db = 3'b000; m_rise = 3'b000; m_pend = 3'b000;
            m_coin = 3'b000; m_busy = 1'b0; m_drop = 1'b0;
            last_rst = ecount; last_start = -1000;
        end else begin
            // level flips once the last DB post-reset samples all disagree with it
            for (int ch = 0; ch < 3; ch++) begin
                flips = (ecount - DB + 1 > last_rst);
                for (int j = 0; j < DB; j++)
                    if (sout(ecount - j, ch) == m_db[ch]) flips = 1'b0;
                new_db[ch] = flips ? ~m_db[ch] : m_db[ch];
            end
            grant = 3'b000;
            if (ecount >= last_start + GAP + 2) begin
                if (m_pend[0])      grant = 3'b001;
                else if (m_pend[1]) grant = 3'b010;
                else if (m_pend[2]) grant = 3'b100;
            end
            m_drop = |(m_rise & m_pend & ~grant);
            m_pend = (m_pend & ~grant) | m_rise;
            m_coin = grant;
            if (grant != 3'b000) last_start = ecount;
            m_busy = (ecount >= last_start) && (ecount <= last_start + GAP);
            m_rise = new_db & ~m_db;
            m_db   = new_db;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    logic       chk_en = 1'b0;
    logic [2:0] prev_coin = 3'b000;
    int         pulse_cnt [3] = '{0, 0, 0};
    int         drop_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("coin_vs_model", int'(coin), int'(m_coin));
            check("busy_vs_model", int'(busy), int'(m_busy));
            check("drop_vs_model", int'(coin_dropped), int'(m_drop));
            check("coin_onehot", int'($countones(coin) <= 1), 1);
            check("coin_back_to_back", int'((coin != 3'b000) && (prev_coin != 3'b000)), 0);
            for (int i = 0; i < 3; i++) pulse_cnt[i] += int'(coin[i]);
            drop_cnt += int'(coin_dropped);
        end
        prev_coin = coin;
    end

    // ---------------- directed stimulus ----------------
    int n0, d0, q0, x0;

    task automatic idle(input int n);
        btn_nickel = 1'b0; btn_dime = 1'b0; btn_quarter = 1'b0; reset = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        n0 = pulse_cnt[0]; d0 = pulse_cnt[1]; q0 = pulse_cnt[2]; x0 = drop_cnt;
    endtask

    task automatic check_counts(input string tag, input int n, input int d, input int q, input int x);
        check({tag, "_nickel_pulses"}, pulse_cnt[0] - n0, n);
        check({tag, "_dime_pulses"},   pulse_cnt[1] - d0, d);
        check({tag, "_quarter_pulses"}, pulse_cnt[2] - q0, q);
        check({tag, "_drops"},         drop_cnt - x0, x);
    endtask

    initial begin
        reset = 1'b1; btn_nickel = 1'b0; btn_dime = 1'b0; btn_quarter = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_coin", int'(coin), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_drop", int'(coin_dropped), 0);
        chk_en = 1'b1;
        idle(10);

        // 1: single dime press, first sampled at offset 0
        snap();
        for (int k = 0; k < 40; k++) begin
            btn_dime = (k < 20);
            @(negedge clk);
            if (k == 6) check("t1_coin_early", int'(coin), 0);
            if (k == 7) check("t1_coin_pulse", int'(coin), 2);
            if (k == 8) check("t1_coin_after", int'(coin), 0);
            if (k >= 7 && k <= 10) check("t1_busy_high", int'(busy), 1);
            if (k == 11) check("t1_busy_low", int'(busy), 0);
        end
        check_counts("t1", 0, 1, 0, 0);
        idle(20);

        // 2: nickel bounce, no run reaches the debounce length
        snap();
        for (int k = 0; k < 30; k++) begin
            btn_nickel = (k < 3) || (k >= 5 && k < 8);
            @(negedge clk);
            check("t2_coin_quiet", int'(coin), 0);
        end
        check_counts("t2", 0, 0, 0, 0);
        idle(20);

        // 3: all three pressed together
        snap();
        for (int k = 0; k < 45; k++) begin
            btn_nickel = (k < 30); btn_dime = (k < 30); btn_quarter = (k < 30);
            @(negedge clk);
            if (k == 7)  check("t3_first_nickel", int'(coin), 1);
            if (k == 11) check("t3_idle_slot", int'(coin), 0);
            if (k == 12) check("t3_second_dime", int'(coin), 2);
            if (k == 17) check("t3_third_quarter", int'(coin), 4);
        end
        check_counts("t3", 1, 1, 1, 0);
        idle(20);

        // 4: quarter pressed, released, pressed again
        snap();
        for (int k = 0; k < 90; k++) begin
            btn_quarter = (k < 30) || (k >= 40 && k < 70);
            @(negedge clk);
            if (k == 7)  check("t4_first_press", int'(coin), 4);
            if (k == 47) check("t4_second_press", int'(coin), 4);
        end
        check_counts("t4", 0, 0, 2, 0);
        idle(20);

        // 5: dime re-pressed while still queued behind nickel traffic
        snap();
        for (int k = 0; k < 50; k++) begin
            btn_quarter = (k < 30);
            btn_nickel  = (k >= 2 && k < 6) || (k >= 10 && k < 30);
            btn_dime    = (k >= 6 && k < 10) || (k >= 14 && k < 30);
            @(negedge clk);
            if (k == 7)  check("t5_quarter", int'(coin), 4);
            if (k == 12) check("t5_nickel_a", int'(coin), 1);
            if (k == 17) check("t5_nickel_b", int'(coin), 1);
            if (k == 19) check("t5_drop_before", int'(coin_dropped), 0);
            if (k == 20) check("t5_drop_pulse", int'(coin_dropped), 1);
            if (k == 21) check("t5_drop_after", int'(coin_dropped), 0);
            if (k == 22) check("t5_dime", int'(coin), 2);
        end
        check_counts("t5", 2, 1, 1, 1);
        idle(20);

        // 6a: reset during nickel PULSE with dime queued, both released
        snap();
        for (int k = 0; k < 30; k++) begin
            btn_nickel = (k < 8); btn_dime = (k < 8); reset = (k == 8);
            @(negedge clk);
            if (k == 7) check("t6a_nickel_inflight", int'(coin), 1);
            if (k == 8) check("t6a_reset_coin", int'(coin), 0);
            if (k == 8) check("t6a_reset_busy", int'(busy), 0);
        end
        check_counts("t6a", 1, 0, 0, 0);
        idle(20);

        // 6b: same, dime still held through reset
        snap();
        for (int k = 0; k < 40; k++) begin
            btn_nickel = (k < 8); btn_dime = (k < 30); reset = (k == 8);
            @(negedge clk);
            if (k == 8)  check("t6b_reset_coin", int'(coin), 0);
            if (k == 15) check("t6b_coin_early", int'(coin), 0);
            if (k == 16) check("t6b_dime_after_reset", int'(coin), 2);
        end
        check_counts("t6b", 1, 1, 0, 0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage directly upstream of the vending machine FSM.
- Turns three raw, bouncy, asynchronous board pushbuttons (nickel, dime, quarter) into clean one-cycle, one-hot `coin[2:0]` pulses.
- The FSM adds credit on every cycle that `coin` is non-zero, so each physical press must yield exactly one single-cycle pulse, with idle spacing between pulses.
- Handles synchronisation, debouncing, edge detection, queuing of simultaneous presses and pulse spacing.

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before the debounced level changes. Minimum 1.
- `GAP_CYCLES`, default 4: forced `coin==0` cycles after each pulse. Minimum 1.

Ports:
- `clk`  in  1  system clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_nickel`  in  1  raw pushbutton, asynchronous, active-high.
- `btn_dime`  in  1  raw pushbutton, asynchronous, active-high.
- `btn_quarter`  in  1  raw pushbutton, asynchronous, active-high.
- `coin`  out  3  one-hot coin pulse: 001 = 5c, 010 = 10c, 100 = 25c, else 000. Registered.
- `busy`  out  1  high while in PULSE or GAP. Registered.
- `coin_dropped`  out  1  one-cycle pulse when a press is discarded. Registered.

Behaviour:
- Reset (synchronous, active-high): at the edge where `reset`=1, all of the following clear:
  - synchroniser flops, debounce counters, debounced levels (to 0), edge-detect history, pending flags;
  - FSM goes to IDLE;
  - `coin`=000, `busy`=0, `coin_dropped`=0.
  - Reset overrides every other event at that edge, including an in-flight PULSE or GAP; no partial pulse survives.
- Per-button channel (three identical instances, bit i: 0 = nickel, 1 = dime, 2 = quarter):
  - Synchroniser: 2-flop chain; `s_out` is the button delayed 2 edges.
  - Debounce: counter width `clog2(DEBOUNCE_CYCLES+1)`.
    - If `s_out` == debounced level `db`: counter clears.
    - Otherwise, if counter == `DEBOUNCE_CYCLES`-1: `db` toggles and counter clears.
    - Otherwise: counter increments.
    - A single differing sample shorter than `DEBOUNCE_CYCLES` never changes `db`.
  - Rise detect: `rise` = `db` & ~`db_q` (`db_q` is `db` delayed one edge). Falling edges are ignored.
  - Pending flag: set at the edge after `rise`.
    - If `rise` occurs while the flag is already set and is not being granted at that edge: the press is discarded and `coin_dropped`=1 for one cycle.
    - If a grant clears the flag at the same edge a new `rise` sets it: set wins.
- Arbiter FSM states: IDLE, PULSE, GAP.
  - IDLE: if any pending flag is set, the next edge goes to PULSE, loads `coin` with the one-hot of the lowest-index pending bit (nickel > dime > quarter), and clears that pending bit. Otherwise stay in IDLE with `coin`=000.
  - PULSE: exactly one cycle with `coin` non-zero. Next edge goes to GAP with `coin`=000 and the gap counter loaded with 0.
  - GAP: `coin`=000; counter increments each edge. When the counter == `GAP_CYCLES`-1, the next edge goes to IDLE.
  - Pending flags keep being set during PULSE and GAP; they are served later.
  - `busy` = 1 exactly while the state is PULSE or GAP.
- Spacing: back-to-back pending coins start `GAP_CYCLES`+2 cycles apart (PULSE + GAP + IDLE).
- Latency: if `btn` is first sampled high at edge N, held stable and the FSM is idle:
  - `db` rises after edge N+`DEBOUNCE_CYCLES`+1;
  - pending sets at edge N+`DEBOUNCE_CYCLES`+2;
  - `coin` is high during the cycle after edge N+`DEBOUNCE_CYCLES`+3.
- Held button: produces exactly one pulse. A new pulse needs a debounced release (`db`=0) followed by a new debounced press.
- Button held through reset: `db` restarts at 0, so one coin is produced `DEBOUNCE_CYCLES`+3 edges after reset deasserts.
- Invariants: `coin` is never multi-hot, and never non-zero on two consecutive cycles.

Test Plan (`DEBOUNCE_CYCLES`=4, `GAP_CYCLES`=3):
1. Single press: `btn_dime` high from edge 10, held for 20 cycles. Required: `coin`=010 only in the cycle after edge 17, then 000; `busy` high for 4 cycles.
2. Bounce: `btn_nickel` pulses high for 3 cycles, low for 2, then high for 3, then low. Required: `coin` stays 000 throughout; no pending flag is ever set.
3. Simultaneous: all three buttons rise at the same edge and are held. Required: `coin` = 001, then 010, then 100, with pulse starts exactly 5 cycles apart; never multi-hot.
4. Re-press: quarter held for 30 cycles, released for 10, pressed again. Required: exactly two 100 pulses, one per press.
5. Drop: while the dime pending flag is set and a nickel pulse/gap is in progress, dime is released (debounced) and pressed again. Required: `coin_dropped` is a one-cycle pulse; only one 010 pulse is issued.
6. Reset mid-operation: assert `reset` during the PULSE cycle of a nickel, with a dime pending. Required:
   - at the next edge `coin`=000, `busy`=0, IDLE;
   - no dime pulse follows unless the dime button is still held, in which case one 010 appears 7 edges after reset deasserts.
